reg_share_arb: RTL

Round-robin arbiter and load sequencer for a single WIDTH-bit shared holding register built on the team's mux-based flop/`mux2` datapath. Up to N requesters each present a data word. The block grants one requester at a time, steers that word through the register's load mux, and publishes the held value with the owner's index. It sits between multiple producers and one shared storage element.

---
 rtl/reg_share_pkg.sv | 19 +
 rtl/reg_share_arb_rr_pick.sv | 32 +++
 rtl/reg_share_arb.sv | 113 +++++++++++
 3 files changed

// File: rtl/reg_share_pkg.sv
// Shared state type, default sizing and index-width helper for the
// round-robin shared-register arbiter.
package reg_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

    localparam int DEF_N     = 4;
    localparam int DEF_WIDTH = 8;

    // Index width that never collapses to zero bits for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_share_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping to 0.
module rr_pick
    import reg_share_pkg::*;
#(
    parameter int N = DEF_N,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        j    = 0;
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        // Offsets 1..N visit every index once, with ptr itself searched last.
        for (int i = 1; i <= N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[IW'(j)]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
        if (any) pick[idx] = 1'b1;
    end

endmodule

// File: rtl/reg_share_arb.sv
// Round-robin arbiter steering one requester word into a shared holding register.
// Optional ARB_LOCK_EN adds the lock port and the HOLD state for back-to-back reloads.
module reg_share_arb
    import reg_share_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   din,
`ifdef ARB_LOCK_EN
    input  logic [N-1:0]         lock,
`endif
    output logic [N-1:0]         gnt,
    output logic [WIDTH-1:0]     q,
    output logic                 q_valid,
    output logic [$clog2(N)-1:0] owner
);

    localparam int IW = idx_w(N);

    arb_state_t       state, state_nx;
    logic [N-1:0]     gnt_nx;
    logic [N-1:0]     pick;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    sel_p0;
    logic             load_en;
    logic             hold_ok;
    logic [WIDTH-1:0] word [N];
    logic [WIDTH-1:0] word_sel;
    logic [WIDTH-1:0] q_nx;

    rr_pick #(.N(N)) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    for (genvar i = 0; i < N; i++) begin : g_word
        assign word[i] = din[i*WIDTH +: WIDTH];
    end

    assign word_sel = word[sel_p0];
    assign load_en  = (state == LOAD) || (state == HOLD);

`ifdef ARB_LOCK_EN
    assign hold_ok = lock[sel_p0] && req[sel_p0];
`else
    assign hold_ok = 1'b0;
`endif

    // Per-bit load mux in front of the shared register.
    for (genvar b = 0; b < WIDTH; b++) begin : g_load_mux
        assign q_nx[b] = load_en ? word_sel[b] : q[b];
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = LOAD;
                    gnt_nx   = pick;
                end else begin
                    gnt_nx = '0;
                end
            end
            LOAD, HOLD: begin
                if (hold_ok) begin
                    state_nx = HOLD;
                end else begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    // sel_p0 tracks the granted index; owner only publishes it once q is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            sel_p0  <= '0;
            owner   <= '0;
            ptr     <= IW'(N - 1);
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            q     <= q_nx;
            if (state == IDLE && pick_any) sel_p0 <= pick_idx;
            if (load_en) begin
                q_valid <= 1'b1;
                owner   <= sel_p0;
                ptr     <= sel_p0;
            end
        end
    end

endmodule
